// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
// DIV_N sets the default divisor/quotient width.
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } st_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// compare on N+1 bits against the divisor, subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] rem,
  input  logic         bin,
  input  logic [N-1:0] div,
  output logic [N-1:0] rem_nxt,
  output logic         qbit
);

  logic [N:0] t;

  assign t = {rem, bin};

  // The difference is below div whenever qbit is set,
  // so its low N bits are exact.
  always_comb begin
    qbit    = (t >= {1'b0, div});
    rem_nxt = t[N-1:0];
    if (qbit) rem_nxt = t[N-1:0] - div;
  end

endmodule

// File: rtl/div16u8_seq.sv
// Sequential unsigned restoring divider, 2N/N -> N quotient + N remainder.
// Optional macro DIV_ZERO_FLAG_EN adds the dz port for divide-by-zero.
module div16u8_seq
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dvd,
  input  logic [N-1:0]   dvs,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           ovf
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic           dz
`endif
);

  localparam int CW = clog2(N);

  st_t         state;
  st_t         nstate;
  logic [N-1:0]  rem;
  logic [N-1:0]  qsh;
  logic [N-1:0]  div;
  logic [CW-1:0] cnt;
  logic          ovf_p;
  logic          ovf_chk;
  logic          last;
  logic [N-1:0]  rem_nxt;
  logic          qbit;
`ifdef DIV_ZERO_FLAG_EN
  logic          dz_p;
`endif

  assign ovf_chk = (dvd[2*N-1:N] >= dvs);
  assign last    = (cnt == CW'(N - 1));
  assign busy    = (state == ST_CALC);

  div_step #(.N(N)) u_step (
    .rem     (rem),
    .bin     (qsh[N-1]),
    .div     (div),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nstate;
  end

  // Next-state logic; overflow skips the iteration phase.
  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE: if (start) nstate = ovf_chk ? ST_DONE : ST_CALC;
      ST_CALC: if (last)  nstate = ST_DONE;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // Operand load and iteration; overflow results are preloaded here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      qsh   <= '0;
      div   <= '0;
      cnt   <= '0;
      ovf_p <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_p  <= 1'b0;
`endif
    end else if (state == ST_IDLE && start) begin
      div   <= dvs;
      cnt   <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz_p  <= 1'b0;
`endif
      if (ovf_chk) begin
        qsh   <= '1;
        rem   <= '0;
        ovf_p <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
        if (dvs == '0) begin
          rem   <= dvd[N-1:0];
          ovf_p <= 1'b0;
          dz_p  <= 1'b1;
        end
`endif
      end else begin
        rem   <= dvd[2*N-1:N];
        qsh   <= dvd[N-1:0];
        ovf_p <= 1'b0;
      end
    end else if (state == ST_CALC) begin
      rem <= rem_nxt;
      qsh <= {qsh[N-2:0], qbit};
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers update once per division, with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      r    <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz   <= 1'b0;
`endif
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        q   <= qsh;
        r   <= rem;
        ovf <= ovf_p;
`ifdef DIV_ZERO_FLAG_EN
        dz  <= dz_p;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div16u8_seq.sv
// Directed testbench for div16u8_seq.
// Works with or without DIV_ZERO_FLAG_EN.
module tb_div16u8_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        busy;
  logic        done;
  logic        ovf;
`ifdef DIV_ZERO_FLAG_EN
  logic        dz;
`else
  logic        dz;
  assign dz = 1'b0;
`endif

  int vectors;
  int miscompares;

  div16u8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .dz    (dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One division with start pulsed for one cycle; operands are
  // scrambled right after acceptance to show they are not re-read.
  task automatic run(input string tag,
                     input logic [15:0] a, input logic [7:0] b,
                     input int eq, input int er,
                     input int eo, input int ez,
                     input int elat, input int ebusy);
    int bc;
    int dj;
    int dc;
    int ovl;
    @(negedge clk);
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dvd   = ~a;
    dvs   = ~b;
    bc  = 0;
    dj  = -1;
    dc  = 0;
    ovl = 0;
    for (int j = 0; j < 20; j++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (dj < 0) dj = j;
        if (busy) ovl++;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, dj, elat);
    chk({tag, "_busy"}, bc, ebusy);
    chk({tag, "_npulse"}, dc, 1);
    chk({tag, "_overlap"}, ovl, 0);
    chk({tag, "_q"}, int'(q), eq);
    chk({tag, "_r"}, int'(r), er);
    chk({tag, "_ovf"}, int'(ovf), eo);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, "_dz"}, int'(dz), ez);
`else
    chk({tag, "_dz"}, ez, 0);
`endif
  endtask

  // Waits for done with a cycle budget; returns -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int dc;
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_dz", int'(dz), 0);
    @(negedge clk);
    rst = 1'b0;

    run("d1000_7", 16'd1000, 8'd7, 142, 6, 0, 0, 9, 8);
    run("fe01_ff", 16'hFE01, 8'hFF, 255, 0, 0, 0, 9, 8);
    run("7fff_80", 16'h7FFF, 8'h80, 255, 127, 0, 0, 9, 8);
    run("d5_9", 16'd5, 8'd9, 0, 5, 0, 0, 9, 8);
    run("ovf1234", 16'h1234, 8'h12, 255, 0, 1, 0, 1, 0);
`ifdef DIV_ZERO_FLAG_EN
    run("dz500", 16'd500, 8'd0, 255, 8'hF4, 0, 1, 1, 0);
`else
    run("dz500", 16'd500, 8'd0, 255, 0, 1, 0, 1, 0);
`endif

    // start held high across two divisions
    @(negedge clk);
    dvd   = 16'd100;
    dvs   = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    dvd = 16'd99;
    dvs = 8'd9;
    wait_done(lat);
    chk("hold1_lat", lat, 9);
    chk("hold1_q", int'(q), 10);
    chk("hold1_r", int'(r), 0);
    chk("hold1_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("hold2_acc", int'(busy), 1);
    wait_done(lat);
    chk("hold2_lat", lat, 9);
    chk("hold2_q", int'(q), 11);
    chk("hold2_r", int'(r), 0);
    @(negedge clk);
    start = 1'b0;

    // reset in the middle of an iteration
    @(negedge clk);
    dvd   = 16'd1000;
    dvs   = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("mid_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_q", int'(q), 0);
    chk("mid_r", int'(r), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    dc  = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk);
      #1;
      if (done || busy) dc++;
    end
    chk("mid_nodone", dc, 0);
    run("after_rst", 16'd1000, 8'd7, 142, 6, 0, 0, 9, 8);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
